// File: rtl/cgra_config_serializer.sv
// MSB-first word-to-bitstream serializer for the CGRA configuration chain.
// Define CFG_SERIALIZER_CRC_EN to add a running CRC-16-CCITT on crc_out.
module cgra_config_serializer #(
  parameter int WORD_WIDTH = 32,
  parameter int TOTAL_BITS = 1024
) (
  input  logic                            clock,
  input  logic                            sync_reset_n,
  input  logic                            enable,
  input  logic [WORD_WIDTH-1:0]           word_in,
  input  logic                            word_valid,
  output logic                            word_ready,
  output logic                            bitstream,
  output logic                            shift_en,
  output logic                            done,
  output logic [$clog2(TOTAL_BITS+1)-1:0] bit_count,
  output logic [15:0]                     crc_out
);

  localparam int CW = $clog2(TOTAL_BITS + 1);
  localparam int WW = $clog2(WORD_WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(TOTAL_BITS - 1);
  localparam logic [CW-1:0] FULL = CW'(TOTAL_BITS);
  localparam logic [WW-1:0] WLEN = WW'(WORD_WIDTH);
  localparam logic [WW-1:0] WONE = WW'(1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [WORD_WIDTH-1:0] shift_reg;
  logic [WW-1:0]         word_left;
  logic [CW-1:0]         count;
  logic                  handshake;
  logic                  last_bit;

  assign handshake = word_ready && word_valid;
  // A word ends at its own last bit or at the chain boundary, whichever is first.
  assign last_bit  = (word_left == WONE) || (count == LAST);
  assign bitstream = shift_reg[WORD_WIDTH-1];
  assign bit_count = count;

  always_comb begin
    state_nx   = state;
    word_ready = 1'b0;
    shift_en   = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable) state_nx = LOAD;
      end
      LOAD: begin
        word_ready = 1'b1;
        if (word_valid) state_nx = SHIFT;
      end
      SHIFT: begin
        shift_en = enable;
        if (enable && last_bit) begin
          state_nx = (count == LAST) ? DONE : LOAD;
        end
      end
      DONE: begin
        done = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!sync_reset_n) begin
      state     <= IDLE;
      shift_reg <= '0;
      word_left <= '0;
      count     <= '0;
    end else begin
      state <= state_nx;
      if (handshake) begin
        shift_reg <= word_in;
        word_left <= WLEN;
      end else if (shift_en) begin
        shift_reg <= {shift_reg[WORD_WIDTH-2:0], 1'b0};
        word_left <= word_left - 1'b1;
        if (count != FULL) count <= count + 1'b1;
      end
    end
  end

`ifdef CFG_SERIALIZER_CRC_EN
  logic [15:0] crc;
  logic        feedback;

  assign feedback = crc[15] ^ bitstream;
  assign crc_out  = crc;

  always_ff @(posedge clock) begin
    if (!sync_reset_n) begin
      crc <= 16'hFFFF;
    end else if (shift_en) begin
      crc <= {crc[14:0], 1'b0} ^ (feedback ? 16'h1021 : 16'h0000);
    end
  end
`else
  assign crc_out = 16'h0000;
`endif

endmodule

// File: tb/tb_cgra_config_serializer.sv
// Scoreboard bench: random/std sessions, pauses, mid-run reset, DONE checks.
// Reference model is a bit queue filled at each accepted word.
module tb_cgra_config_serializer;

  localparam int W  = 8;
  localparam int T  = 76;
  localparam int CW = $clog2(T + 1);

  logic          clock;
  logic          sync_reset_n;
  logic          enable;
  logic [W-1:0]  word_in;
  logic          word_valid;
  logic          word_ready;
  logic          bitstream;
  logic          shift_en;
  logic          done;
  logic [CW-1:0] bit_count;
  logic [15:0]   crc_out;

  int total = 0;
  int bad   = 0;

  bit exp_q[$];
  bit hist[$];
  int cnt    = 0;
  int pushed = 0;
  bit armed    = 0;
  bit rst_prev = 0;
  bit std_run  = 0;
  bit std_crc_checked = 0;
  logic [15:0] exp_crc;

`ifdef CFG_SERIALIZER_CRC_EN
  localparam logic [15:0] CRC_INIT = 16'hFFFF;
`else
  localparam logic [15:0] CRC_INIT = 16'h0000;
`endif

  cgra_config_serializer #(
    .WORD_WIDTH(W),
    .TOTAL_BITS(T)
  ) dut (
    .clock       (clock),
    .sync_reset_n(sync_reset_n),
    .enable      (enable),
    .word_in     (word_in),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .bitstream   (bitstream),
    .shift_en    (shift_en),
    .done        (done),
    .bit_count   (bit_count),
    .crc_out     (crc_out)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  // CRC-16-CCITT over the first n shifted bits, message-order.
  function automatic logic [15:0] crc_of(input int n);
    logic [15:0] c;
    bit fb;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      fb = c[15] ^ hist[i];
      c  = c << 1;
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  always @(negedge clock) begin
    if (armed) begin
      if (rst_prev) begin
        chk("rst_ready", 32'(word_ready), 32'd0);
        chk("rst_shift_en", 32'(shift_en), 32'd0);
        chk("rst_bitstream", 32'(bitstream), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_crc", 32'(crc_out), 32'(CRC_INIT));
      end
      chk("bit_count", 32'(bit_count), 32'(cnt));
      chk("done", 32'(done), 32'(cnt == T));
      chk("crc", 32'(crc_out), 32'(exp_crc));
      if (cnt == T) begin
        chk("done_ready", 32'(word_ready), 32'd0);
        chk("done_shift_en", 32'(shift_en), 32'd0);
      end
      if (std_run && cnt == 72 && !std_crc_checked) begin
        std_crc_checked = 1;
`ifdef CFG_SERIALIZER_CRC_EN
        chk("crc_123456789", 32'(crc_out), 32'h29B1);
`else
        chk("crc_123456789", 32'(crc_out), 32'h0000);
`endif
      end
    end
    if (!sync_reset_n) begin
      armed    = 1;
      rst_prev = 1;
      cnt      = 0;
      pushed   = 0;
      exp_q.delete();
      hist.delete();
      exp_crc  = CRC_INIT;
      std_crc_checked = 0;
    end else begin
      rst_prev = 0;
      if (armed && shift_en) begin
        chk("shift_gated", 32'(enable), 32'd1);
        if (exp_q.size() == 0) begin
          chk("underflow", 32'(bitstream), 32'hDEAD);
        end else begin
          bit e;
          e = exp_q.pop_front();
          chk("bit", 32'(bitstream), 32'(e));
          hist.push_back(e);
          cnt++;
`ifdef CFG_SERIALIZER_CRC_EN
          exp_crc = crc_of(hist.size());
`endif
        end
      end
      if (armed && word_valid && word_ready) begin
        for (int i = W - 1; i >= 0; i--) begin
          if (pushed < T) begin
            exp_q.push_back(word_in[i]);
            pushed++;
          end
        end
      end
    end
  end

  task automatic do_reset(input int n);
    sync_reset_n = 1'b0;
    enable       = 1'b0;
    word_valid   = 1'b0;
    repeat (n) @(posedge clock);
    #1;
    sync_reset_n = 1'b1;
  endtask

  function automatic logic [W-1:0] pick(input bit std, input int k);
    logic [W-1:0] v;
    if (std && k < 9) v = W'(8'h31 + k);
    else v = W'($urandom);
    return v;
  endfunction

  // std: enable/valid held high; rst_at >= 0 pulses reset at that bit count.
  task automatic run(input bit std, input int rst_at);
    int k = 0;
    int cyc = 0;
    bit hs;
    bit seen = 0;
    logic [CW-1:0] bc;
    std_run    = std;
    word_in    = pick(std, 0);
    enable     = 1'b1;
    word_valid = 1'b1;
    while (cyc < 3000) begin
      @(negedge clock);
      hs = word_valid && word_ready;
      bc = bit_count;
      if (done) begin
        seen = 1;
        break;
      end
      cyc++;
      @(posedge clock);
      #1;
      if (hs) begin
        k++;
        word_in = pick(std, k);
      end
      if (!std) begin
        enable     = ($urandom_range(0, 9) < 7);
        word_valid = ($urandom_range(0, 9) < 6);
      end
      if (rst_at >= 0 && int'(bc) == rst_at) begin
        do_reset(1);
        return;
      end
    end
    chk("run_done", 32'(seen), 32'd1);
    if (std) chk("cycles", 32'(cyc), 32'(1 + (T + W - 1) / W + T));
  endtask

  task automatic stick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
      enable     = 1'($urandom);
      word_valid = 1'($urandom);
      word_in    = W'($urandom);
    end
    @(negedge clock);
    chk("stick_done", 32'(done), 32'd1);
  endtask

  initial begin
    sync_reset_n = 1'b0;
    enable       = 1'b0;
    word_valid   = 1'b0;
    word_in      = '0;
    exp_crc      = CRC_INIT;
    do_reset(3);
    run(1, -1);
    stick(12);
    for (int s = 0; s < 4; s++) begin
      do_reset(2);
      run(0, -1);
      stick(8);
    end
    do_reset(2);
    run(0, 17);
    run(1, -1);
    stick(6);
    do_reset(2);
    @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
